// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//   Four-digit seven-segment display controller. A captured binary value is
//   saturated to 9999, converted to BCD by a sequential double-dabble engine
//   (14 shifts), and the resulting digits are time-multiplexed onto shared,
//   active-low segment lines. Leading zeros are blanked through the anode
//   enables; the decimal point on the units digit flags an overflow.
//
// Parameters
//   SCAN_DIV  clock cycles each digit is held before the scan advances (>=2)
//
// Ports
//   clk   in   system clock
//   rst   in   asynchronous, active-high reset
//   num   in   [31:0] unsigned value to display
//   load  in   single-cycle capture request, honoured only while idle
//   busy  out  high while a conversion is in progress
//   an    out  [3:0] digit anodes, active-low, bit0 = units digit
//   seg   out  [7:0] segments, active-low, {dp,g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] num,
    input  logic        load,
    output logic        busy,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [31:0]     MAX_SHOW = 32'd9999;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state_q, state_d;
    logic [13:0]       sat_q, sat_d;      // saturated binary being shifted out
    logic [15:0]       scr_q, scr_d;      // BCD scratch
    logic [3:0]        cnt_q, cnt_d;      // shifts remaining
    logic              ovf_n_q, ovf_n_d;  // overflow flag of the pending value
    logic [15:0]       disp_q, disp_d;    // displayed digits {d3,d2,d1,d0}
    logic              ovf_q, ovf_d;      // overflow flag of the displayed value
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        idx_q, idx_d;

    logic [15:0]       adj;
    logic [3:0]        mask;
    logic [3:0]        digit;
    logic [6:0]        seg_lo;

    // -----------------------------------------------------------------------
    // Conversion FSM
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch to hold it.
        state_d = state_q;
        sat_d   = sat_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        ovf_n_d = ovf_n_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        adj     = scr_q;

        case (state_q)
            IDLE: begin
                if (load) begin
                    sat_d   = (num > MAX_SHOW) ? 14'd9999 : num[13:0];
                    ovf_n_d = (num > MAX_SHOW);
                    scr_d   = '0;
                    cnt_d   = 4'd14;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                for (int i = 0; i < 4; i++) begin
                    if (scr_q[4*i +: 4] >= 4'd5) begin
                        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
                    end
                end
                // The top scratch bit falls off; the value never exceeds 9999.
                {scr_d, sat_d} = {adj, sat_q} << 1;
                cnt_d = cnt_q - 4'd1;
                // Last shift: publish all four digits in one step so the scan
                // never shows a mix of old and new digits.
                if (cnt_q == 4'd1) begin
                    disp_d  = scr_d;
                    ovf_d   = ovf_n_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Scan divider and digit index
    // -----------------------------------------------------------------------
    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sat_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            ovf_n_q <= 1'b0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            div_q   <= '0;
            idx_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            sat_q   <= sat_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            ovf_n_q <= ovf_n_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
        end
    end

    // -----------------------------------------------------------------------
    // Display outputs (combinational from idx, digits and overflow)
    // -----------------------------------------------------------------------
    assign busy = (state_q == SHIFT);

    // Leading-zero blanking: a digit lights if it or any higher digit is
    // non-zero; the units digit always lights.
    assign mask[0] = 1'b1;
    assign mask[1] = (disp_q[15:4]  != '0);
    assign mask[2] = (disp_q[15:8]  != '0);
    assign mask[3] = (disp_q[15:12] != '0);

    assign digit = disp_q[4*idx_q +: 4];

    always_comb begin
        case (digit)
            4'd0:    seg_lo = 7'h40;
            4'd1:    seg_lo = 7'h79;
            4'd2:    seg_lo = 7'h24;
            4'd3:    seg_lo = 7'h30;
            4'd4:    seg_lo = 7'h19;
            4'd5:    seg_lo = 7'h12;
            4'd6:    seg_lo = 7'h02;
            4'd7:    seg_lo = 7'h78;
            4'd8:    seg_lo = 7'h00;
            4'd9:    seg_lo = 7'h10;
            default: seg_lo = 7'h7F;
        endcase
    end

    assign an  = ~((4'b0001 << idx_q) & mask);
    assign seg = {~(ovf_q && (idx_q == 2'd0)), seg_lo};

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Self-checking bench for seg_scan_ctrl with SCAN_DIV = 4. Expected display
//   contents come from a table of hand-computed vectors and, for random
//   values, from an arithmetic model (saturate, divide/modulo into digits,
//   blank by magnitude). The scan position is predicted from the number of
//   clock edges since reset.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int SCAN_DIV = 4;

    logic        clk;
    logic        rst;
    logic [31:0] num;
    logic        load;
    logic        busy;
    logic [3:0]  an;
    logic [7:0]  seg;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    int unsigned tb_cyc;

    seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .num  (num),
        .load (load),
        .busy (busy),
        .an   (an),
        .seg  (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since reset; the scan position follows from this count.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= 0;
        else     tb_cyc <= tb_cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] num;
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  mask;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Reference model: saturate, split into decimal digits, blank by magnitude.
    task automatic model(input logic [31:0] v, output logic [15:0] bcd,
                         output logic ovf, output logic [3:0] mask);
        int unsigned s;
        ovf = (v > 9999);
        s   = ovf ? 9999 : v;
        bcd = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
        mask = {s >= 1000, s >= 100, s >= 10, 1'b1};
    endtask

    // Watch one full frame (16 cycles), predicting idx from the edge count.
    task automatic check_frame(input logic [15:0] bcd, input logic ovf, input logic [3:0] mask);
        int idx;
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        repeat (4 * SCAN_DIV) begin
            @(negedge clk);
            idx     = int'((tb_cyc / SCAN_DIV) % 4);
            exp_an  = ~((4'b0001 << idx) & mask);
            exp_seg = seg_code(bcd[4*idx +: 4]);
            if (ovf && idx == 0) exp_seg[7] = 1'b0;
            check($sformatf("an idx%0d", idx), 32'(an), 32'(exp_an));
            check($sformatf("seg idx%0d", idx), 32'(seg), 32'(exp_seg));
        end
    endtask

    // Call right after a negedge: load is sampled at the next posedge (edge N).
    task automatic start_load(input logic [31:0] v);
        num  = v;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    // busy must be high after edges N..N+13 and low after N+14. Optionally
    // raises load (with inj_num) for the edge following step inj_k.
    task automatic run_conv(input int inj_k, input logic [31:0] inj_num);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            check($sformatf("busy high step%0d", k), 32'(busy), 32'd1);
            if (k == inj_k) begin
                num  = inj_num;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
        @(negedge clk);
        check("busy low after 14", 32'(busy), 32'd0);
        load = 1'b0;
    endtask

    initial begin
        logic [15:0] m_bcd;
        logic        m_ovf;
        logic [3:0]  m_mask;
        logic [31:0] v;

        vecs[0] = '{32'd7,      16'h0007, 1'b0, 4'b0001};
        vecs[1] = '{32'd1205,   16'h1205, 1'b0, 4'b1111};
        vecs[2] = '{32'd123456, 16'h9999, 1'b1, 4'b1111};
        vecs[3] = '{32'd0,      16'h0000, 1'b0, 4'b0001};
        vecs[4] = '{32'd10,     16'h0010, 1'b0, 4'b0011};
        vecs[5] = '{32'd100,    16'h0100, 1'b0, 4'b0111};
        vecs[6] = '{32'd1000,   16'h1000, 1'b0, 4'b1111};
        vecs[7] = '{32'd9999,   16'h9999, 1'b0, 4'b1111};
        vecs[8] = '{32'd10000,  16'h9999, 1'b1, 4'b1111};

        // Reset: outputs settle before the first clock edge.
        rst  = 1'b1;
        load = 1'b0;
        num  = '0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset an",   32'(an),   32'h E);
        check("reset seg",  32'(seg),  32'h C0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset hold an",  32'(an),  32'h E);
        check("reset hold seg", 32'(seg), 32'h C0);
        rst = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            start_load(vecs[i].num);
            run_conv(-1, 32'd0);
            check_frame(vecs[i].bcd, vecs[i].ovf, vecs[i].mask);
        end

        // Load while busy: the second request is dropped, 42 stays.
        start_load(32'd42);
        run_conv(2, 32'd8);
        check_frame(16'h0042, 1'b0, 4'b0011);

        // Load on the finishing edge is ignored; one cycle later is accepted.
        start_load(32'd31);
        run_conv(13, 32'd5);
        start_load(32'd64);
        run_conv(-1, 32'd0);
        check_frame(16'h0064, 1'b0, 4'b0011);

        // Reset mid-conversion aborts; display returns to zero immediately.
        start_load(32'd9999);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset an",   32'(an),   32'h E);
        check("mid reset seg",  32'(seg),  32'h C0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_frame(16'h0000, 1'b0, 4'b0001);
        start_load(32'd9);
        run_conv(-1, 32'd0);
        check_frame(16'h0009, 1'b0, 4'b0001);

        // Randomized values against the arithmetic model.
        for (int r = 0; r < 20; r++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom;
                1:       v = $urandom_range(0, 9999);
                2:       v = $urandom_range(0, 99);
                default: v = $urandom_range(9990, 10010);
            endcase
            model(v, m_bcd, m_ovf, m_mask);
            start_load(v);
            run_conv(-1, 32'd0);
            check_frame(m_bcd, m_ovf, m_mask);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
